decoder_seq_en: RTL and testbench

DECODER_SEQ_EN -- requirements
Module: decoder_seq_en

---
 rtl/decoder_seq_en.sv | 126 ++++++++++++
 tb/tb_decoder_seq_en.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_seq_en.sv
// Registered one-hot decoder with DIRECT, PULSE (rising-edge of en) and SCAN
// (walks all outputs once from a start index, pausable via en) modes.
module decoder_seq_en #(
    parameter int SEL_W = 3
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic [SEL_W-1:0]      data,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic                  start,
    output logic [2**SEL_W-1:0]   out,
    output logic [SEL_W-1:0]      sel,
    output logic                  valid,
    output logic                  scan_done,
    output logic                  busy
);
    localparam int OUTS = 2**SEL_W;
    localparam logic [SEL_W:0] OUTS_C = (SEL_W+1)'(OUTS);

    typedef enum logic [1:0] {
        M_DIRECT = 2'b00,
        M_PULSE  = 2'b01,
        M_SCAN   = 2'b10,
        M_RSVD   = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W:0]    cnt_q, cnt_d;
    logic              en_q;
    logic [OUTS-1:0]   out_q, out_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;

    logic              hit;
    logic [SEL_W-1:0]  idx;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        hit     = 1'b0;
        idx     = data;
        done_d  = 1'b0;

        unique case (mode_e'(mode))
            M_DIRECT: begin
                state_d = IDLE;
                hit     = en;
            end
            M_PULSE: begin
                state_d = IDLE;
                hit     = en & ~en_q;
            end
            M_SCAN: begin
                if (state_q == IDLE) begin
                    if (start && en) begin
                        state_d = SCAN;
                        ptr_d   = data;
                        cnt_d   = (SEL_W+1)'(1);
                        hit     = 1'b1;
                        idx     = data;
                    end
                end else if (en) begin
                    // cnt counts outputs already shown; OUTS shown means the walk is complete
                    if (cnt_q < OUTS_C) begin
                        ptr_d  = ptr_q + 1'b1;
                        cnt_d  = cnt_q + 1'b1;
                        hit    = 1'b1;
                        idx    = ptr_q + 1'b1;
                        done_d = (cnt_q + 1'b1) == OUTS_C;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        out_d   = '0;
        sel_d   = '0;
        valid_d = hit;
        if (hit) begin
            out_d[idx] = 1'b1;
            sel_d      = idx;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            out_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            en_q    <= en;
            out_q   <= out_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign out       = out_q;
    assign sel       = sel_q;
    assign valid     = valid_q;
    assign scan_done = done_q;
    assign busy      = (state_q == SCAN);

endmodule

// File: tb/tb_decoder_seq_en.sv
// Bench for decoder_seq_en: directed scenarios plus random traffic against a
// queue-based reference model of the decode/pulse/scan behaviour.
module tb_decoder_seq_en;
    localparam int SEL_W = 3;
    localparam int OUTS  = 1 << SEL_W;

    logic              clock = 1'b0;
    logic              ctrl_reset_n;
    logic [SEL_W-1:0]  data;
    logic              en;
    logic [1:0]        mode;
    logic              start;
    logic [OUTS-1:0]   out;
    logic [SEL_W-1:0]  sel;
    logic              valid;
    logic              scan_done;
    logic              busy;

    decoder_seq_en #(.SEL_W(SEL_W)) dut (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n), .data(data), .en(en),
        .mode(mode), .start(start), .out(out), .sel(sel), .valid(valid),
        .scan_done(scan_done), .busy(busy)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: a scan is a queue of the indices still to be shown.
    bit              m_scan;
    bit              m_enq;
    int              m_q[$];
    logic [OUTS-1:0] e_out;
    int              e_sel;
    bit              e_valid, e_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_scan = 0; m_enq = 0; m_q.delete();
        e_out = '0; e_sel = 0; e_valid = 0; e_done = 0;
    endtask

    task automatic model_eval();
        bit hit; int idx;
        hit = 0; idx = int'(data); e_done = 0;
        case (mode)
            2'b00: begin m_scan = 0; hit = en; end
            2'b01: begin m_scan = 0; hit = en && !m_enq; end
            2'b10: begin
                if (!m_scan) begin
                    if (start && en) begin
                        m_q.delete();
                        for (int k = 0; k < OUTS; k++) m_q.push_back((int'(data) + k) % OUTS);
                        idx = m_q.pop_front(); hit = 1; m_scan = 1;
                        e_done = (m_q.size() == 0);
                    end
                end else if (en) begin
                    if (m_q.size() > 0) begin
                        idx = m_q.pop_front(); hit = 1;
                        e_done = (m_q.size() == 0);
                    end else m_scan = 0;
                end
            end
            default: m_scan = 0;
        endcase
        m_enq   = en;
        e_valid = hit;
        e_sel   = hit ? idx : 0;
        e_out   = hit ? (OUTS'(1) << idx) : '0;
    endtask

    task automatic drive(input int d, input bit e, input int m, input bit s);
        data = SEL_W'(d); en = e; mode = 2'(m); start = s;
    endtask

    task automatic step(input string tag);
        model_eval();
        @(posedge clock);
        #1;
        chk({tag, ".out"},   32'(out),       32'(e_out));
        chk({tag, ".sel"},   32'(sel),       32'(e_sel));
        chk({tag, ".valid"}, 32'(valid),     32'(e_valid));
        chk({tag, ".done"},  32'(scan_done), 32'(e_done));
        chk({tag, ".busy"},  32'(busy),      32'(m_scan));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".out"},   32'(out),       32'h0);
        chk({tag, ".sel"},   32'(sel),       32'h0);
        chk({tag, ".valid"}, 32'(valid),     32'h0);
        chk({tag, ".done"},  32'(scan_done), 32'h0);
        chk({tag, ".busy"},  32'(busy),      32'h0);
    endtask

    logic [OUTS-1:0] scan_exp [8];
    int onehots;

    initial begin
        scan_exp = '{8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
        ctrl_reset_n = 1'b0;
        drive(0, 0, 0, 0);
        model_reset();
        #12;
        chk_zero("reset");
        ctrl_reset_n = 1'b1;

        // DIRECT sweep and disable
        for (int d = 0; d < OUTS; d++) begin
            drive(d, 1, 0, 0); step("direct");
            chk("direct.const", 32'(out), 32'(1) << d);
        end
        drive(3, 0, 0, 0); step("direct_off");

        // PULSE: one pulse per en rising edge, data changes ignored while high
        drive(5, 0, 1, 0); step("pulse_lo");
        drive(5, 1, 1, 0); step("pulse_first");
        chk("pulse.const", 32'(out), 32'h20);
        drive(5, 1, 1, 0); step("pulse_hold");
        drive(2, 1, 1, 0); step("pulse_hold_d");
        drive(5, 1, 1, 0); step("pulse_hold2");
        drive(5, 0, 1, 0); step("pulse_drop");
        drive(5, 1, 1, 0); step("pulse_again");
        drive(5, 1, 1, 0); step("pulse_again_hold");
        // Entering PULSE with en already high gives no pulse
        drive(1, 1, 0, 0); step("pre_pulse_direct");
        drive(1, 1, 1, 0); step("pulse_entry_high");

        // SCAN from 6
        drive(6, 0, 2, 0); step("scan_idle");
        drive(6, 1, 2, 1); step("scan0");
        chk("scan.const", 32'(out), 32'(scan_exp[0]));
        drive(6, 1, 2, 0);
        for (int i = 1; i < OUTS; i++) begin
            step("scan");
            chk("scan.const", 32'(out), 32'(scan_exp[i]));
            chk("scan.done_const", 32'(scan_done), 32'(i == OUTS - 1));
        end
        step("scan_end");
        chk("scan_end.busy", 32'(busy), 32'h0);

        // SCAN pause after 3rd output, counting one-hot outputs
        onehots = 0;
        drive(0, 1, 2, 1); step("pause"); onehots += int'(valid);
        drive(0, 1, 2, 1); step("pause_startign"); onehots += int'(valid);
        drive(0, 1, 2, 0); step("pause"); onehots += int'(valid);
        drive(0, 0, 2, 0); step("paused");
        drive(0, 0, 2, 1); step("paused");
        drive(0, 1, 2, 0); step("resume");
        chk("resume.const", 32'(out), 32'h08);
        onehots += int'(valid);
        for (int i = 0; i < 5; i++) begin step("resume"); onehots += int'(valid); end
        step("pause_end");
        chk("pause.count", 32'(onehots), 32'(OUTS));

        // Abort to DIRECT, and forced idle by reserved mode
        drive(2, 1, 2, 1); step("abort_scan");
        drive(2, 1, 2, 0); step("abort_scan");
        drive(2, 1, 0, 0); step("abort");
        chk("abort.const", 32'(out), 32'h04);
        drive(7, 1, 2, 1); step("rsvd_scan");
        drive(7, 1, 3, 0); step("rsvd");
        drive(7, 0, 2, 1); step("start_en0");

        // Asynchronous reset mid-scan
        drive(4, 1, 2, 1); step("rst_scan");
        drive(4, 1, 2, 0); step("rst_scan");
        #2 ctrl_reset_n = 1'b0;
        #1 chk_zero("async_rst");
        model_reset();
        @(posedge clock);
        #2 ctrl_reset_n = 1'b1;
        chk_zero("rst_hold");
        drive(4, 1, 2, 0);
        for (int i = 0; i < 3; i++) step("post_rst_idle");
        drive(4, 1, 2, 1); step("post_rst_start");

        // Random traffic, mode biased toward SCAN
        for (int i = 0; i < 800; i++) begin
            int r;
            r = $urandom_range(0, 9);
            drive($urandom_range(0, OUTS - 1), $urandom_range(0, 4) != 0,
                  (r < 2) ? 0 : (r < 4) ? 1 : (r < 9) ? 2 : 3,
                  $urandom_range(0, 3) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
